// File: rtl/census_pkg.sv
// ============================================================================
// census_pkg : shared types and elaboration helpers for the census window ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

package census_pkg;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Bits needed to count 0..value-1; evaluated at elaboration only.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int half_win(input int win);
        return (win - 1) / 2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/census_window_ctrl_raster_counter.sv
// ============================================================================
// raster_counter : column/row raster position with frame restart and wrap flags
// Rev 1.0
// ============================================================================
`default_nettype none

module raster_counter
    import census_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int COL_W = 10,
    parameter int ROW_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_restart,
    output logic [COL_W-1:0] o_col,
    output logic [ROW_W-1:0] o_row,
    output logic             o_col_last,
    output logic             o_row_last
);

    localparam logic [COL_W-1:0] c_COL_MAX = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] c_ROW_MAX = ROW_W'(IMG_H - 1);

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] w_cur_col;
    logic [ROW_W-1:0] w_cur_row;

    // A restart consumes the current pixel as (0,0), so advance from there.
    always_comb begin
        w_cur_col = i_restart ? '0 : r_col;
        w_cur_row = i_restart ? '0 : r_row;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_en) begin
            if (w_cur_col == c_COL_MAX) begin
                r_col <= '0;
                r_row <= (w_cur_row == c_ROW_MAX) ? '0 : w_cur_row + 1'b1;
            end else begin
                r_col <= w_cur_col + 1'b1;
                r_row <= w_cur_row;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (COL_W >= clog2(IMG_W) && ROW_W >= clog2(IMG_H)
                    && r_col <= c_COL_MAX && r_row <= c_ROW_MAX);
        end
    end

    assign o_col      = r_col;
    assign o_row      = r_row;
    assign o_col_last = (r_col == c_COL_MAX);
    assign o_row_last = (r_row == c_ROW_MAX);

endmodule

`default_nettype wire

// File: rtl/census_window_ctrl.sv
// ============================================================================
// census_window_ctrl : raster sequencer flagging complete interior census windows
// Rev 1.0
// ============================================================================
`default_nettype none

module census_window_ctrl
    import census_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int WIN   = 7,
    parameter int COL_W = 10,
    parameter int ROW_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sof,
    output logic             in_ready,
    output logic             shift_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [COL_W-1:0] win_col,
    output logic [ROW_W-1:0] win_row,
    output logic             frame_done,
    output logic             sof_err
);

    localparam int               c_H       = half_win(WIN);
    localparam logic [COL_W-1:0] c_COL_H   = COL_W'(c_H);
    localparam logic [ROW_W-1:0] c_ROW_H   = ROW_W'(c_H);
    localparam logic [COL_W-1:0] c_COL_MIN = COL_W'(WIN - 1);
    localparam logic [ROW_W-1:0] c_ROW_MIN = ROW_W'(WIN - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_shift;
    logic             w_restart;
    logic             w_sof_err;
    logic             w_frame_end;
    logic             w_qual;
    logic [COL_W-1:0] w_col;
    logic [ROW_W-1:0] w_row;
    logic             w_col_last;
    logic             w_row_last;
    logic [COL_W-1:0] w_pix_col;
    logic [ROW_W-1:0] w_pix_row;

    logic             r_out_valid;
    logic [COL_W-1:0] r_win_col;
    logic [ROW_W-1:0] r_win_row;
    logic             r_frame_done;
    logic             r_sof_err;

    raster_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .COL_W (COL_W),
        .ROW_W (ROW_W)
    ) u_raster_counter (
        .clk        (clk),
        .rst        (rst),
        .i_en       (w_shift),
        .i_restart  (w_restart),
        .o_col      (w_col),
        .o_row      (w_row),
        .o_col_last (w_col_last),
        .o_row_last (w_row_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_in_ready   = !r_out_valid || out_ready;
        w_accept     = in_valid && w_in_ready;
        // Position of the pixel entering the taps; an sof pixel is always (0,0).
        w_pix_col    = in_sof ? '0 : w_col;
        w_pix_row    = in_sof ? '0 : w_row;
        w_qual       = (w_pix_row >= c_ROW_MIN) && (w_pix_col >= c_COL_MIN);
        w_next_state = r_state;
        w_shift      = 1'b0;
        w_restart    = 1'b0;
        w_sof_err    = 1'b0;
        w_frame_end  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && in_sof) begin
                    w_shift      = 1'b1;
                    w_restart    = 1'b1;
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (w_accept) begin
                    w_shift = 1'b1;
                    if (in_sof) begin
                        w_restart = 1'b1;
                        w_sof_err = 1'b1;
                    end else if (w_col_last && w_row_last) begin
                        w_frame_end  = 1'b1;
                        w_next_state = S_IDLE;
                    end
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_win_col    <= '0;
            r_win_row    <= '0;
            r_frame_done <= 1'b0;
            r_sof_err    <= 1'b0;
        end else begin
            r_frame_done <= w_frame_end;
            r_sof_err    <= w_sof_err;
            if (w_shift && w_qual) begin
                r_out_valid <= 1'b1;
                r_win_col   <= w_pix_col - c_COL_H;
                r_win_row   <= w_pix_row - c_ROW_H;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign shift_en   = w_shift;
    assign out_valid  = r_out_valid;
    assign win_col    = r_win_col;
    assign win_row    = r_win_row;
    assign frame_done = r_frame_done;
    assign sof_err    = r_sof_err;

endmodule

`default_nettype wire

// File: tb/tb_census_window_ctrl.sv
// ============================================================================
// tb_census_window_ctrl : directed and random stimulus against a raster-index model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_census_window_ctrl;

    localparam int IMG_W = 8;
    localparam int IMG_H = 8;
    localparam int WIN   = 3;
    localparam int COL_W = 4;
    localparam int ROW_W = 4;
    localparam int H     = (WIN - 1) / 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_sof = 1'b0;
    logic             out_ready = 1'b0;
    logic             in_ready;
    logic             shift_en;
    logic             out_valid;
    logic [COL_W-1:0] win_col;
    logic [ROW_W-1:0] win_row;
    logic             frame_done;
    logic             sof_err;

    int n_checks = 0;
    int n_errors = 0;

    // Model: frame membership and linear index of the next pixel in the frame.
    bit m_inframe;
    int m_idx;
    bit m_ov;
    int m_wc;
    int m_wr;
    bit m_fd;
    bit m_se;

    int dut_hs;
    int dut_fd;
    int dut_se;

    census_window_ctrl #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .WIN   (WIN),
        .COL_W (COL_W),
        .ROW_W (ROW_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_ready   (in_ready),
        .shift_en   (shift_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .win_col    (win_col),
        .win_row    (win_row),
        .frame_done (frame_done),
        .sof_err    (sof_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_inframe = 1'b0;
        m_idx     = 0;
        m_ov      = 1'b0;
        m_wc      = 0;
        m_wr      = 0;
    endtask

    task automatic check_quiet_outputs(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_win_col"}, win_col, 0);
        check({tag, "_win_row"}, win_row, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_sof_err"}, sof_err, 0);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_shift_en"}, shift_en, 0);
    endtask

    // One clock: entered and left 1 time unit after a rising edge.
    task automatic step(input bit v, input bit s, input bit r, output bit acc);
        bit rdy;
        bit shift;
        bit qual;
        int rr;
        int cc;
        in_valid  = v;
        in_sof    = s;
        out_ready = r;
        #1;
        rdy   = !m_ov || r;
        acc   = v && rdy;
        shift = acc && (m_inframe || s);
        check("in_ready", in_ready, rdy);
        check("shift_en", shift_en, shift);
        if (out_valid === 1'b1 && r) dut_hs++;
        @(posedge clk);
        #1;
        m_fd = 1'b0;
        m_se = 1'b0;
        qual = 1'b0;
        if (shift) begin
            if (s) begin
                m_se      = m_inframe;
                m_inframe = 1'b1;
                m_idx     = 0;
            end
            rr = m_idx / IMG_W;
            cc = m_idx % IMG_W;
            if (rr >= WIN - 1 && cc >= WIN - 1) begin
                qual = 1'b1;
                m_wr = rr - H;
                m_wc = cc - H;
            end
            if (m_idx == IMG_W * IMG_H - 1) begin
                m_fd      = 1'b1;
                m_inframe = 1'b0;
                m_idx     = 0;
            end else begin
                m_idx++;
            end
        end
        if (qual) m_ov = 1'b1;
        else if (r) m_ov = 1'b0;
        check("out_valid", out_valid, m_ov);
        check("frame_done", frame_done, m_fd);
        check("sof_err", sof_err, m_se);
        if (m_ov) begin
            check("win_col", win_col, m_wc);
            check("win_row", win_row, m_wr);
        end
        if (frame_done === 1'b1) dut_fd++;
        if (sof_err === 1'b1) dut_se++;
    endtask

    // mode 0: always ready; 1: hold out_ready low for the first 5 valid-window cycles; 2: random
    task automatic run_pixels(input int n, input bit sof_first, input int mode);
        int sent;
        int stall_left;
        bit acc;
        bit v;
        bit s;
        bit r;
        sent       = 0;
        stall_left = 5;
        for (int cyc = 0; cyc < 4000 && sent < n; cyc++) begin
            v = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            s = sof_first && (sent == 0) && v;
            if (mode == 2) begin
                r = 1'($urandom_range(0, 1));
            end else if (mode == 1 && m_ov && stall_left > 0) begin
                r = 1'b0;
                stall_left--;
            end else begin
                r = 1'b1;
            end
            step(v, s, r, acc);
            if (acc) sent++;
        end
        check("pixels_sent", sent, n);
    endtask

    task automatic drain(input int k);
        bit acc;
        for (int i = 0; i < k; i++) begin
            step(1'b0, 1'b0, 1'b1, acc);
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_quiet_outputs("reset");
        rst = 1'b0;

        // Full frame, no backpressure
        dut_hs = 0;
        dut_fd = 0;
        run_pixels(64, 1'b1, 0);
        drain(3);
        check("A_windows", dut_hs, 36);
        check("A_frame_done", dut_fd, 1);

        // Backpressure on the first window
        dut_hs = 0;
        dut_fd = 0;
        run_pixels(64, 1'b1, 1);
        drain(3);
        check("B_windows", dut_hs, 36);
        check("B_frame_done", dut_fd, 1);

        // Pixels without sof while idle are discarded
        dut_hs = 0;
        run_pixels(10, 1'b0, 0);
        check("C_idle_windows", dut_hs, 0);
        dut_fd = 0;
        run_pixels(64, 1'b1, 0);
        drain(3);
        check("C_windows", dut_hs, 36);
        check("C_frame_done", dut_fd, 1);

        // Resync: sof on pixel 20 restarts the raster
        dut_hs = 0;
        dut_se = 0;
        dut_fd = 0;
        run_pixels(20, 1'b1, 0);
        run_pixels(64, 1'b1, 0);
        drain(3);
        check("D_sof_err", dut_se, 1);
        check("D_windows", dut_hs, 38);
        check("D_frame_done", dut_fd, 1);

        // Asynchronous reset in row 4, between clock edges
        run_pixels(35, 1'b1, 0);
        #2;
        in_valid  = 1'b1;
        in_sof    = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b1;
        #1;
        check_quiet_outputs("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        rst    = 1'b0;
        dut_hs = 0;
        dut_fd = 0;
        run_pixels(64, 1'b1, 0);
        drain(3);
        check("E_windows", dut_hs, 36);
        check("E_frame_done", dut_fd, 1);

        // Random valid/ready over three frames
        dut_hs = 0;
        dut_fd = 0;
        repeat (3) run_pixels(64, 1'b1, 2);
        drain(4);
        check("F_windows", dut_hs, 108);
        check("F_frame_done", dut_fd, 3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
